// File: rtl/led_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_arb_pkg
// Description : Shared types and helpers for the LED display arbiter.
//               - state_t : arbiter FSM state encoding (IDLE/SHOW/GAP)
//               - LED_W   : number of board LEDs driven by the arbiter
//               - rr_next : round-robin successor index, wrapping at n
// Revision    : 1.0 - initial release
// ============================================================================
package led_arb_pkg;

    localparam int LED_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Index that follows idx in a ring of n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_tick_gen
// Description : Free-running tick prescaler. Counts 0..CLKS_PER_TICK-1 and
//               asserts o_Tick during the terminal count. i_Clear restarts
//               the count so a phase that starts on a clear lasts an exact
//               multiple of CLKS_PER_TICK cycles.
// Ports       : i_Clk   - system clock
//               i_Rst_L - synchronous reset, active low
//               i_Clear - restart the count from 0 on the next edge
//               o_Tick  - high for one cycle every CLKS_PER_TICK cycles
// Revision    : 1.0 - initial release
// ============================================================================
module led_tick_gen #(
    parameter int CLKS_PER_TICK = 25000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Clear,
    output logic o_Tick
);

    localparam int CNT_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLKS_PER_TICK - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L || i_Clear) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_Tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/led_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : led_display_arbiter
// Description : Round-robin sharing of the four board LEDs between NUM_REQ
//               requesters. A grant shows the winner's pattern for
//               HOLD_TICKS ticks, then blanks the LEDs for GAP_TICKS ticks.
//               While idle, LED 1 blinks with a BLINK_TICKS half-period.
// Ports       : i_Clk      - system clock
//               i_Rst_L    - synchronous reset, active low
//               i_Req      - per-requester display request (level)
//               i_Pattern  - requester n pattern at [4n+3:4n], bit 0 = LED 1
//               o_Gnt      - one-hot grant, high while pattern is shown
//               o_Done     - one-cycle pulse when a grant's hold expires
//               o_Busy     - high while showing or in the blank gap
//               o_LED_1..4 - registered LED drives
// Revision    : 1.0 - initial release
// ============================================================================
module led_display_arbiter
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int CLKS_PER_TICK = 25000,
    parameter int HOLD_TICKS    = 500,
    parameter int GAP_TICKS     = 50,
    parameter int BLINK_TICKS   = 250
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst_L,
    input  logic [NUM_REQ-1:0]         i_Req,
    input  logic [LED_W*NUM_REQ-1:0]   i_Pattern,
    output logic [NUM_REQ-1:0]         o_Gnt,
    output logic [NUM_REQ-1:0]         o_Done,
    output logic                       o_Busy,
    output logic                       o_LED_1,
    output logic                       o_LED_2,
    output logic                       o_LED_3,
    output logic                       o_LED_4
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int HOLD_W  = $clog2(HOLD_TICKS + 1);
    localparam int GAP_W   = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam int BLINK_W = $clog2(BLINK_TICKS + 1);

    localparam logic [HOLD_W-1:0]  c_HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [GAP_W-1:0]   c_GAP_LAST   = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [BLINK_W-1:0] c_BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    state_t               r_state;
    logic [IDX_W-1:0]     r_rr;
    logic [IDX_W-1:0]     r_winner;
    logic [HOLD_W-1:0]    r_hold_cnt;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic [BLINK_W-1:0]   r_blink_cnt;
    logic                 r_hb;
    logic [LED_W-1:0]     r_led;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_busy;

    logic                 w_tick;
    logic                 w_clear;
    logic                 w_req_any;
    logic                 w_show_done;
    logic                 w_gap_done;
    logic [IDX_W-1:0]     w_sel;
    logic [LED_W-1:0]     w_sel_pat;
    int                   w_dist;
    int                   w_best;

    assign w_req_any   = |i_Req;
    assign w_show_done = (r_state == SHOW) && w_tick && (r_hold_cnt == c_HOLD_LAST);
    assign w_gap_done  = (r_state == GAP)  && w_tick && (r_gap_cnt == c_GAP_LAST);
    // Every state change restarts the prescaler.
    assign w_clear     = ((r_state == IDLE) && w_req_any) || w_show_done || w_gap_done;

    led_tick_gen #(
        .CLKS_PER_TICK (CLKS_PER_TICK)
    ) u_tick_gen (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Clear (w_clear),
        .o_Tick  (w_tick)
    );

    // Winner = requesting index with the smallest ring distance above r_rr.
    always_comb begin
        w_sel     = '0;
        w_sel_pat = '0;
        w_best    = NUM_REQ;
        w_dist    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = i - int'(r_rr);
            if (w_dist < 0) begin
                w_dist = w_dist + NUM_REQ;
            end
            if (i_Req[i] && (w_dist < w_best)) begin
                w_best    = w_dist;
                w_sel     = IDX_W'(i);
                w_sel_pat = i_Pattern[i*LED_W +: LED_W];
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_state     <= IDLE;
            r_rr        <= '0;
            r_winner    <= '0;
            r_hold_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_blink_cnt <= '0;
            r_hb        <= 1'b0;
            r_led       <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (w_req_any) begin
                        r_state    <= SHOW;
                        r_winner   <= w_sel;
                        r_gnt      <= NUM_REQ'(1) << w_sel;
                        r_led      <= w_sel_pat;
                        r_busy     <= 1'b1;
                        r_hold_cnt <= '0;
                    end else if (w_tick) begin
                        if (r_blink_cnt == c_BLINK_LAST) begin
                            r_blink_cnt <= '0;
                            r_hb        <= ~r_hb;
                            r_led       <= {{(LED_W-1){1'b0}}, ~r_hb};
                        end else begin
                            r_blink_cnt <= r_blink_cnt + 1'b1;
                        end
                    end
                end
                SHOW: begin
                    // Request and pattern inputs are not looked at here:
                    // a grant always runs its full hold time.
                    if (w_tick) begin
                        if (r_hold_cnt == c_HOLD_LAST) begin
                            r_done    <= NUM_REQ'(1) << r_winner;
                            r_gnt     <= '0;
                            r_led     <= '0;
                            r_rr      <= IDX_W'(rr_next(int'(r_winner), NUM_REQ));
                            r_gap_cnt <= '0;
                            if (GAP_TICKS > 0) begin
                                r_state <= GAP;
                            end else begin
                                r_state     <= IDLE;
                                r_busy      <= 1'b0;
                                r_hb        <= 1'b0;
                                r_blink_cnt <= '0;
                            end
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (w_tick) begin
                        if (r_gap_cnt == c_GAP_LAST) begin
                            r_state     <= IDLE;
                            r_busy      <= 1'b0;
                            r_hb        <= 1'b0;
                            r_blink_cnt <= '0;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_Gnt   = r_gnt;
    assign o_Done  = r_done;
    assign o_Busy  = r_busy;
    assign o_LED_1 = r_led[0];
    assign o_LED_2 = r_led[1];
    assign o_LED_3 = r_led[2];
    assign o_LED_4 = r_led[3];

endmodule
`default_nettype wire
